reg_file_sb: RTL and testbench
==============================

Name: reg_file_sb

Overview:
- Parametrised successor to the single-write-port ARMv4 register bank.
- Three asynchronous read ports (Rn/Rm/Rs style) and two synchronous write ports: A for ALU result, B for load writeback.
- Dedicated PC register with auto-increment, plus a per-register pending-load scoreboard that flags read hazards to the control FSM.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 4, register index width; NUM_REGS = 2**ADDR_W.
- PC_IDX, 15, index of the program counter register.
- PC_STEP, 4, PC increment per pc_inc pulse.
- RESET_PC, 0, PC value after reset.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- wa_en  in  1  write port A enable.
- wa_addr  in  ADDR_W  write port A index.
- wa_data  in  DATA_W  write port A data.
- wb_en  in  1  write port B enable (load writeback).
- wb_addr  in  ADDR_W  write port B index.
- wb_data  in  DATA_W  write port B data.
- ld_issue  in  1  load issued; marks ld_addr pending.
- ld_addr  in  ADDR_W  destination of issued load.
- pc_inc  in  1  advance PC by PC_STEP.
- ra_addr, rb_addr, rc_addr  in  ADDR_W  read indices.
- ra_data, rb_data, rc_data  out  DATA_W  read data.
- hazard  out  1  any read port addresses a pending register.
- pc  out  DATA_W  current PC.
- pending  out  NUM_REGS  scoreboard bit vector, bit i = register i pending.

Behaviour:
- Reset (rst_n low, asynchronous):
  - All general registers are 0; PC is RESET_PC; pending is 0.
  - Therefore ra/rb/rc_data = 0 (or RESET_PC at PC_IDX), hazard = 0, pc = RESET_PC.
  - Reset asserted mid-operation discards all same-cycle writes and issues.
- Reads are combinational from stored state.
  - Address PC_IDX returns the stored PC.
  - A write becomes visible on the cycle after the clock edge (1-cycle write latency) unless REGFILE_BYPASS_EN is defined.
- Writes at posedge clk:
  - wa_en: reg[wa_addr] <= wa_data.
  - wb_en: reg[wb_addr] <= wb_data.
  - Same address on both ports in the same cycle: port B wins.
- PC update priority, per cycle:
  1. Write to PC_IDX (port B over port A).
  2. Otherwise pc_inc: pc <= pc + PC_STEP, modulo 2**DATA_W; wraps from all-ones region to low values with no flag.
  3. Otherwise hold.
  - A write to PC_IDX in the same cycle as pc_inc suppresses the increment.
- Scoreboard, per register i, at posedge:
  - ld_issue with ld_addr==i sets bit i.
  - Otherwise wb_en with wb_addr==i clears bit i.
  - Issue and clear of the same index in the same cycle: bit stays set (new load outstanding).
  - Issue to an already-pending register: stays set; a single outstanding load per register is assumed by control.
  - Port A writes never clear pending bits.
  - ld_issue with ld_addr==PC_IDX is legal and tracked like any other index.
- hazard = pending[ra_addr] | pending[rb_addr] | pending[rc_addr], evaluated combinationally from the registered scoreboard.
- No combinational path from write ports to hazard.

Optional Feature:
- Macro REGFILE_BYPASS_EN.
- Defined: each read port forwards same-cycle write data when its address matches an enabled write port (port B over port A); PC_IDX forwards the PC write value.
  - hazard is masked for a port whose address matches wb_addr with wb_en high, because the load data is forwarded.
- Undefined: reads return stored state only; no forwarding, no masking.

Test Plan:
- Reset with rst_n=0 mid-write (wa_en=1, wa_addr=3, wa_data=32'hDEAD) -> after release reg3=0, pc=RESET_PC=0, pending=0, hazard=0.
- wa_en=1 and wb_en=1, both addr 5, data 32'h11 / 32'h22 -> next cycle ra_addr=5 reads 32'h22; without bypass the same-cycle read returns old value 0.
- pc_inc=1 for 3 cycles from pc=0 -> pc=12; then wb_en=1, wb_addr=15, wb_data=32'h100 with pc_inc=1 -> pc=32'h100 (no increment). Start at pc=32'hFFFFFFFC with pc_inc -> pc=0.
- ld_issue, ld_addr=7 -> pending[7]=1; rb_addr=7 -> hazard=1; wb_en, wb_addr=7, data 32'h55 -> next cycle pending[7]=0, hazard=0, rb_data=32'h55.
- ld_issue addr 2 and wb_en addr 2 in the same cycle -> pending[2] stays 1 and reg2 updated; port A write to reg2 -> pending[2] still 1.
- With REGFILE_BYPASS_EN defined: wb_en=1, wb_addr=4, wb_data=32'hABCD, ra_addr=4 and pending[4]=1 -> same-cycle ra_data=32'hABCD, hazard=0.

Source files
------------

// File: rtl/reg_file_sb_if.sv
// reg_file_sb_if: write, load-tracking, PC and read bus of the scoreboarded register file
interface reg_file_sb_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
);
  localparam int NUM_REGS = 2 ** ADDR_W;
  logic                wa_en;
  logic [ADDR_W-1:0]   wa_addr;
  logic [DATA_W-1:0]   wa_data;
  logic                wb_en;
  logic [ADDR_W-1:0]   wb_addr;
  logic [DATA_W-1:0]   wb_data;
  logic                ld_issue;
  logic [ADDR_W-1:0]   ld_addr;
  logic                pc_inc;
  logic [ADDR_W-1:0]   ra_addr;
  logic [ADDR_W-1:0]   rb_addr;
  logic [ADDR_W-1:0]   rc_addr;
  logic [DATA_W-1:0]   ra_data;
  logic [DATA_W-1:0]   rb_data;
  logic [DATA_W-1:0]   rc_data;
  logic                hazard;
  logic [DATA_W-1:0]   pc;
  logic [NUM_REGS-1:0] pending;
  modport master (
    output wa_en, wa_addr, wa_data, wb_en, wb_addr, wb_data,
           ld_issue, ld_addr, pc_inc, ra_addr, rb_addr, rc_addr,
    input  ra_data, rb_data, rc_data, hazard, pc, pending
  );
  modport slave (
    input  wa_en, wa_addr, wa_data, wb_en, wb_addr, wb_data,
           ld_issue, ld_addr, pc_inc, ra_addr, rb_addr, rc_addr,
    output ra_data, rb_data, rc_data, hazard, pc, pending
  );
endinterface

// File: rtl/reg_file_sb.sv
// reg_file_sb: 3R/2W register file with auto-incrementing PC and pending-load scoreboard
// Optional same-cycle write forwarding and hazard masking when REGFILE_BYPASS_EN is defined.
module reg_file_sb #(
  parameter int               DATA_W   = 32,
  parameter int               ADDR_W   = 4,
  parameter int               PC_IDX   = 15,
  parameter int               PC_STEP  = 4,
  parameter logic [DATA_W-1:0] RESET_PC = '0
) (
  input logic          clk,
  input logic          rst_n,
  reg_file_sb_if.slave io_bus
);
  localparam int                  NUM_REGS = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0]   PC_A     = ADDR_W'(PC_IDX);
  localparam logic [DATA_W-1:0]   STEP     = DATA_W'(PC_STEP);
  localparam logic [NUM_REGS-1:0] ONE      = NUM_REGS'(1);
  logic [DATA_W-1:0]   r_regs [NUM_REGS];
  logic [DATA_W-1:0]   r_pc;
  logic [NUM_REGS-1:0] r_pend;
  logic [DATA_W-1:0]   w_pc_nxt;
  logic [NUM_REGS-1:0] w_set;
  logic [NUM_REGS-1:0] w_clr;
  logic                w_wa_pc;
  logic                w_wb_pc;
  logic [ADDR_W-1:0]   w_raddr [3];
  logic [DATA_W-1:0]   w_rdata [3];
  logic [2:0]          w_haz;
  assign w_wa_pc = io_bus.wa_en && io_bus.wa_addr == PC_A;
  assign w_wb_pc = io_bus.wb_en && io_bus.wb_addr == PC_A;
  assign w_pc_nxt = w_wb_pc ? io_bus.wb_data :
                    w_wa_pc ? io_bus.wa_data :
                    io_bus.pc_inc ? r_pc + STEP : r_pc;
  // issue is applied after the clear so a same-cycle new load keeps the bit set
  assign w_set = {NUM_REGS{io_bus.ld_issue}} & (ONE << io_bus.ld_addr);
  assign w_clr = {NUM_REGS{io_bus.wb_en}} & (ONE << io_bus.wb_addr);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int k = 0; k < NUM_REGS; k++) r_regs[k] <= '0;
      r_pc   <= RESET_PC;
      r_pend <= '0;
    end else begin
      if (io_bus.wa_en) r_regs[io_bus.wa_addr] <= io_bus.wa_data;
      if (io_bus.wb_en) r_regs[io_bus.wb_addr] <= io_bus.wb_data;
      r_pc   <= w_pc_nxt;
      r_pend <= (r_pend & ~w_clr) | w_set;
    end
  assign w_raddr[0] = io_bus.ra_addr;
  assign w_raddr[1] = io_bus.rb_addr;
  assign w_raddr[2] = io_bus.rc_addr;
  always_comb
    for (int p = 0; p < 3; p++) begin
`ifdef REGFILE_BYPASS_EN
      w_rdata[p] = (io_bus.wb_en && io_bus.wb_addr == w_raddr[p]) ? io_bus.wb_data :
                   (io_bus.wa_en && io_bus.wa_addr == w_raddr[p]) ? io_bus.wa_data :
                   (w_raddr[p] == PC_A) ? r_pc : r_regs[w_raddr[p]];
      w_haz[p]   = r_pend[w_raddr[p]] && !(io_bus.wb_en && io_bus.wb_addr == w_raddr[p]);
`else
      w_rdata[p] = (w_raddr[p] == PC_A) ? r_pc : r_regs[w_raddr[p]];
      w_haz[p]   = r_pend[w_raddr[p]];
`endif
    end
  assign io_bus.ra_data = w_rdata[0];
  assign io_bus.rb_data = w_rdata[1];
  assign io_bus.rc_data = w_rdata[2];
  assign io_bus.hazard  = |w_haz;
  assign io_bus.pc      = r_pc;
  assign io_bus.pending = r_pend;
endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb: directed vectors plus a per-cycle reference model of the register file
module tb_reg_file_sb;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic chk_on = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;
  reg_file_sb_if #(.DATA_W(32), .ADDR_W(4)) bus ();
  reg_file_sb dut (.clk(clk), .rst_n(rst_n), .io_bus(bus));
  always #5 clk = ~clk;
  logic [31:0] m_regs [16];
  logic [31:0] m_pc;
  logic [15:0] m_pend;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int k = 0; k < 16; k++) m_regs[k] = 0;
      m_pc   = 0;
      m_pend = 0;
    end else begin
      if (bus.wa_en) m_regs[bus.wa_addr] = bus.wa_data;
      if (bus.wb_en) m_regs[bus.wb_addr] = bus.wb_data;
      if (bus.wb_en && bus.wb_addr == 15) m_pc = bus.wb_data;
      else if (bus.wa_en && bus.wa_addr == 15) m_pc = bus.wa_data;
      else if (bus.pc_inc) m_pc = m_pc + 4;
      if (bus.wb_en) m_pend[bus.wb_addr] = 1'b0;
      if (bus.ld_issue) m_pend[bus.ld_addr] = 1'b1;
    end
  function automatic logic [31:0] exp_rd(input logic [3:0] a);
`ifdef REGFILE_BYPASS_EN
    if (bus.wb_en && bus.wb_addr == a) return bus.wb_data;
    if (bus.wa_en && bus.wa_addr == a) return bus.wa_data;
`endif
    return a == 15 ? m_pc : m_regs[a];
  endfunction
  function automatic logic exp_pend(input logic [3:0] a);
`ifdef REGFILE_BYPASS_EN
    if (bus.wb_en && bus.wb_addr == a) return 1'b0;
`endif
    return m_pend[a];
  endfunction
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask
  always @(negedge clk)
    if (rst_n && chk_on) begin
      check("model ra_data", bus.ra_data, exp_rd(bus.ra_addr));
      check("model rb_data", bus.rb_data, exp_rd(bus.rb_addr));
      check("model rc_data", bus.rc_data, exp_rd(bus.rc_addr));
      check("model hazard", 32'(bus.hazard),
            32'(exp_pend(bus.ra_addr) | exp_pend(bus.rb_addr) | exp_pend(bus.rc_addr)));
      check("model pc", bus.pc, m_pc);
      check("model pending", 32'(bus.pending), 32'(m_pend));
    end
  task automatic tick();
    @(posedge clk);
    #1;
    bus.wa_en = 0; bus.wb_en = 0; bus.ld_issue = 0; bus.pc_inc = 0;
  endtask
  task automatic rd(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
    bus.ra_addr = a; bus.rb_addr = b; bus.rc_addr = c;
  endtask
  initial begin
    bus.wa_en = 0; bus.wa_addr = 0; bus.wa_data = 0;
    bus.wb_en = 0; bus.wb_addr = 0; bus.wb_data = 0;
    bus.ld_issue = 0; bus.ld_addr = 0; bus.pc_inc = 0;
    rd(0, 0, 0);
    tick(); tick();
    rst_n = 1'b1;
    chk_on = 1'b1;
    // dirty some state, then reset in the middle of a write/issue/inc cycle
    bus.wa_en = 1; bus.wa_addr = 3; bus.wa_data = 32'h77;
    bus.ld_issue = 1; bus.ld_addr = 9; bus.pc_inc = 1;
    tick();
    rd(3, 9, 0);
    bus.wa_en = 1; bus.wa_addr = 3; bus.wa_data = 32'hDEAD;
    bus.ld_issue = 1; bus.ld_addr = 9; bus.pc_inc = 1;
    #2 rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    check("reset reg3", bus.ra_data, 32'h0);
    check("reset pc", bus.pc, 32'h0);
    check("reset pending", 32'(bus.pending), 32'h0);
    check("reset hazard", 32'(bus.hazard), 32'h0);
    // fill 0..14 alternating ports, read back on all three ports
    for (int i = 0; i < 15; i++) begin
      if (i % 2 == 0) begin bus.wa_en = 1; bus.wa_addr = 4'(i); bus.wa_data = 32'h1111_0000 + i; end
      else begin bus.wb_en = 1; bus.wb_addr = 4'(i); bus.wb_data = 32'h1111_0000 + i; end
      tick();
    end
    for (int i = 0; i < 15; i++) begin
      rd(4'(i), 4'((i + 1) % 15), 4'(14 - i));
      #1 check("fill ra", bus.ra_data, 32'h1111_0000 + i);
      tick();
    end
    // both ports to reg5: B wins
    rd(5, 0, 0);
    bus.wa_en = 1; bus.wa_addr = 5; bus.wa_data = 32'h11;
    bus.wb_en = 1; bus.wb_addr = 5; bus.wb_data = 32'h22;
    #1;
`ifdef REGFILE_BYPASS_EN
    check("same-cycle reg5", bus.ra_data, 32'h22);
`else
    check("same-cycle reg5", bus.ra_data, 32'h1111_0005);
`endif
    tick();
    check("reg5 B wins", bus.ra_data, 32'h22);
    // PC increment, write-over-increment, wrap
    bus.pc_inc = 1; tick();
    bus.pc_inc = 1; tick();
    bus.pc_inc = 1; tick();
    check("pc after 3 inc", bus.pc, 32'd12);
    rd(15, 0, 0);
    #1 check("read pc port", bus.ra_data, 32'd12);
    bus.wb_en = 1; bus.wb_addr = 15; bus.wb_data = 32'h100; bus.pc_inc = 1;
    tick();
    check("pc write beats inc", bus.pc, 32'h100);
    bus.wa_en = 1; bus.wa_addr = 15; bus.wa_data = 32'hFFFF_FFFC;
    tick();
    check("pc load", bus.pc, 32'hFFFF_FFFC);
    bus.pc_inc = 1; tick();
    check("pc wrap", bus.pc, 32'h0);
    // load to r7, hazard, then writeback clears it
    rd(0, 0, 0);
    bus.ld_issue = 1; bus.ld_addr = 7;
    tick();
    rd(0, 7, 0);
    #1;
    check("pend7 set", 32'(bus.pending[7]), 32'h1);
    check("hazard r7", 32'(bus.hazard), 32'h1);
    bus.wb_en = 1; bus.wb_addr = 7; bus.wb_data = 32'h55;
    tick();
    check("pend7 cleared", 32'(bus.pending[7]), 32'h0);
    check("hazard r7 gone", 32'(bus.hazard), 32'h0);
    check("r7 loaded", bus.rb_data, 32'h55);
    // issue + writeback on r2 same cycle, then port A write
    bus.ld_issue = 1; bus.ld_addr = 2;
    bus.wb_en = 1; bus.wb_addr = 2; bus.wb_data = 32'h2222;
    tick();
    rd(2, 0, 0);
    #1;
    check("pend2 kept", 32'(bus.pending[2]), 32'h1);
    check("r2 updated", bus.ra_data, 32'h2222);
    check("hazard r2", 32'(bus.hazard), 32'h1);
    bus.wa_en = 1; bus.wa_addr = 2; bus.wa_data = 32'h3333;
    tick();
    check("pend2 after A", 32'(bus.pending[2]), 32'h1);
    check("r2 A write", bus.ra_data, 32'h3333);
    bus.ld_issue = 1; bus.ld_addr = 15;
    tick();
    check("pend pc tracked", 32'(bus.pending), 32'h8004);
    bus.wb_en = 1; bus.wb_addr = 2; bus.wb_data = 32'h4444;
    tick();
    // load to r4 then writeback observed in the same cycle
    rd(0, 0, 0);
    bus.ld_issue = 1; bus.ld_addr = 4;
    tick();
    rd(4, 0, 0);
    bus.wb_en = 1; bus.wb_addr = 4; bus.wb_data = 32'hABCD;
    #1;
`ifdef REGFILE_BYPASS_EN
    check("bypass r4 data", bus.ra_data, 32'hABCD);
    check("bypass r4 hazard", 32'(bus.hazard), 32'h0);
`else
    check("nobypass r4 data", bus.ra_data, 32'h1111_0004);
    check("nobypass r4 hazard", 32'(bus.hazard), 32'h1);
`endif
    tick();
    check("r4 loaded", bus.ra_data, 32'hABCD);
    check("pend final", 32'(bus.pending), 32'h8000);
    tick();
    chk_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
